// File: rtl/host_mem_arb.sv
// -----------------------------------------------------------------------------
// host_mem_arb
//
// Round-robin arbiter that funnels NUM_REQ cache requesters (line reads and
// line write-backs) onto the single host memory interface of the MMU. One
// transaction is in flight at a time. Each granted request becomes either a
// host rgo/re read handshake or a host wgo/we write handshake.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   host_init                host is up; only looked at while in STARTUP
//   req_valid[NUM_REQ]       per-requester request, held until its req_done
//   req_we[NUM_REQ]          1 = write-back, 0 = line read
//   req_addr                 packed line addresses, lane i at [i*ADDR_W +: ADDR_W]
//   req_wdata                packed write-back lines, lane i at [i*LINE_W +: LINE_W]
//   req_done[NUM_REQ]        one-hot completion pulse, one cycle
//   rsp_data                 read line, valid while req_done pulses for a read
//   host_rd_ready            host read data valid
//   host_wr_ready            host accepts write data
//   host_data_bus_read_in    host read line
//   host_data_bus_write_out  registered write line (holds outside WRITE)
//   cpu_addr                 64-bit host address (0 unless READ/WRITE)
//   host_rgo, host_re        read request / read accept strobe
//   host_wgo, host_we        write request / write commit strobe
//   xfer_count               completed transactions, saturating
//   dbg_state                current FSM state, for observation only
//
// Handshake contract: a requester raises req_valid and holds it, with stable
// req_we/req_addr/req_wdata, until it sees req_done for its lane; it drops
// req_valid on the edge that samples req_done. The arbiter captures the
// request at grant, so later changes on the requester side (including an
// early drop of req_valid) never disturb the transaction in flight. On the
// host side, host_rgo/host_wgo stay high for the whole transaction and the
// matching ready input completes it in the same cycle it is seen; the ready
// input of the other direction is ignored.
// -----------------------------------------------------------------------------
module host_mem_arb #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 16,
    parameter int LINE_W  = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_init,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [LINE_W-1:0]         rsp_data,
    input  logic                      host_rd_ready,
    input  logic                      host_wr_ready,
    input  logic [LINE_W-1:0]         host_data_bus_read_in,
    output logic [LINE_W-1:0]         host_data_bus_write_out,
    output logic [63:0]               cpu_addr,
    output logic                      host_rgo,
    output logic                      host_re,
    output logic                      host_wgo,
    output logic                      host_we,
    output logic [31:0]               xfer_count,
    output logic [1:0]                dbg_state
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_READY   = 2'd1,
        ST_READ    = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         xfer_count_q;

    logic                found;
    logic [GW-1:0]       cand;
    logic [GW-1:0]       win;
    logic [ADDR_W-1:0]   addr_sel;
    logic [LINE_W-1:0]   wdata_sel;
    logic                we_sel;
    logic                grant_load;
    logic                complete;
    logic                busy;

    // The full line address is captured for visibility; only the low IDX_W
    // bits travel to the host.
    logic                addr_unused;
    assign addr_unused = ^addr_q;

    // -------------------------------------------------------------------------
    // Round-robin pick: scan last_grant+1, last_grant+2, ... (mod NUM_REQ) and
    // take the first requester with req_valid set. last_grant itself is
    // scanned last, so a requester that just finished has lowest priority.
    // -------------------------------------------------------------------------
    always_comb begin
        found = 1'b0;
        cand  = '0;
        win   = last_grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Lane mux for the winning requester.
    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == GW'(i)) begin
                addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
                wdata_sel = req_wdata[i*LINE_W +: LINE_W];
                we_sel    = req_we[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STARTUP;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        complete   = 1'b0;
        unique case (state_q)
            ST_STARTUP: begin
                if (host_init) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (found) begin
                    grant_load = 1'b1;
                    state_d    = we_sel ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (host_rd_ready) begin
                    complete = 1'b1;
                    state_d  = ST_READY;
                end
            end
            ST_WRITE: begin
                if (host_wr_ready) begin
                    complete = 1'b1;
                    state_d  = ST_READY;
                end
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transaction latches, fairness pointer, completion counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q                 <= '0;
            last_grant_q            <= GW'(NUM_REQ - 1);
            addr_q                  <= '0;
            host_data_bus_write_out <= '0;
            xfer_count_q            <= '0;
        end else begin
            if (grant_load) begin
                grant_q <= win;
                addr_q  <= addr_sel;
                // Only write-backs touch the write bus register, so it keeps
                // the last written line across reads and idle periods.
                if (we_sel) begin
                    host_data_bus_write_out <= wdata_sel;
                end
            end
            if (complete) begin
                last_grant_q <= grant_q;
                if (xfer_count_q != 32'hFFFF_FFFF) begin
                    xfer_count_q <= xfer_count_q + 32'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy     = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign host_rgo = (state_q == ST_READ);
    assign host_wgo = (state_q == ST_WRITE);
    assign host_re  = host_rgo && host_rd_ready;
    assign host_we  = host_wgo && host_wr_ready;
    assign rsp_data = host_re ? host_data_bus_read_in : '0;

    // Host addresses are word-granular: line index shifted left by two.
    assign cpu_addr = busy ? {{(62-IDX_W){1'b0}}, addr_q[IDX_W-1:0], 2'b00} : 64'd0;

    always_comb begin
        req_done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_done[i] = complete && (grant_q == GW'(i));
        end
    end

    assign xfer_count = xfer_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_host_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_host_mem_arb
//
// Drives directed scenarios followed by a randomized phase. Inputs change on
// the falling edge; outputs are compared shortly after, before the next rising
// edge, against a transaction-level model (idle/busy plus the captured
// request). A grant-order queue is also kept and checked on every completion.
// -----------------------------------------------------------------------------
module tb_host_mem_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int LW = 512;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            host_init;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_wdata;
  logic [N-1:0]    req_done;
  logic [LW-1:0]   rsp_data;
  logic            host_rd_ready;
  logic            host_wr_ready;
  logic [LW-1:0]   host_rd_data;
  logic [LW-1:0]   host_wr_data;
  logic [63:0]     cpu_addr;
  logic            host_rgo;
  logic            host_re;
  logic            host_wgo;
  logic            host_we;
  logic [31:0]     xfer_count;
  logic [1:0]      dbg_state;

  host_mem_arb #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .IDX_W   (IW),
    .LINE_W  (LW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .host_init               (host_init),
    .req_valid               (req_valid),
    .req_we                  (req_we),
    .req_addr                (req_addr),
    .req_wdata               (req_wdata),
    .req_done                (req_done),
    .rsp_data                (rsp_data),
    .host_rd_ready           (host_rd_ready),
    .host_wr_ready           (host_wr_ready),
    .host_data_bus_read_in   (host_rd_data),
    .host_data_bus_write_out (host_wr_data),
    .cpu_addr                (cpu_addr),
    .host_rgo                (host_rgo),
    .host_re                 (host_re),
    .host_wgo                (host_wgo),
    .host_we                 (host_we),
    .xfer_count              (xfer_count),
    .dbg_state               (dbg_state)
  );

  // ---------------------------------------------------------------- checking
  int checks;
  int errors;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit          m_started;
  bit          m_busy;
  bit          m_we;
  bit          m_complete;
  int          m_g;
  int          m_last;
  logic [31:0] m_addr;
  logic [LW-1:0] m_wr_out;
  logic [31:0] m_count;

  // scoreboard: grant indices in issue order, retired by req_done
  logic [1:0]  exp_q[$];
  int          done_log[$];
  logic [N-1:0] last_done;
  bit          auto_drop;

  task automatic model_reset();
    m_started  = 0;
    m_busy     = 0;
    m_we       = 0;
    m_complete = 0;
    m_g        = 0;
    m_last     = N - 1;
    m_addr     = '0;
    m_wr_out   = '0;
    m_count    = '0;
    exp_q.delete();
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_outputs();
    bit            cmp;
    logic [N-1:0]  e_done;
    logic [63:0]   e_addr;
    int            idx;
    cmp    = m_busy && (m_we ? host_wr_ready : host_rd_ready);
    e_done = cmp ? N'(1 << m_g) : '0;
    e_addr = m_busy ? (64'(m_addr) % 64'(1 << IW)) * 64'd4 : 64'd0;
    check("rgo",       host_rgo,     m_busy && !m_we);
    check("wgo",       host_wgo,     m_busy && m_we);
    check("re",        host_re,      cmp && !m_we);
    check("we",        host_we,      cmp && m_we);
    check("done",      req_done,     e_done);
    check("rsp",       rsp_data,     (cmp && !m_we) ? host_rd_data : '0);
    check("addr",      cpu_addr,     e_addr);
    check("wdata_out", host_wr_data, m_wr_out);
    check("count",     xfer_count,   m_count);
    m_complete = cmp;
    last_done  = req_done;
    if (req_done != '0) begin
      idx = -1;
      for (int i = 0; i < N; i++) if (req_done[i]) idx = i;
      done_log.push_back(idx);
      if (exp_q.size() == 0) check("sb_unexpected", req_done, '0);
      else check("sb_order", idx, exp_q.pop_front());
    end
  endtask

  task automatic model_step();
    bit found;
    found = 0;
    if (!m_started) begin
      m_started = host_init;
    end else if (!m_busy) begin
      if (req_valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (!found && req_valid[i]) begin
            found = 1;
            m_g   = i;
          end
        end
        m_we   = req_we[m_g];
        m_addr = req_addr[m_g*AW +: AW];
        if (m_we) m_wr_out = req_wdata[m_g*LW +: LW];
        m_busy = 1;
        exp_q.push_back(2'(m_g));
      end
    end else if (m_complete) begin
      m_busy = 0;
      m_last = m_g;
      if (m_count != 32'hFFFF_FFFF) m_count++;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Called on a falling edge with inputs already set for this cycle.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (auto_drop) req_valid = req_valid & ~last_done;
  endtask

  task automatic do_reset();
    host_init = 0;
    rst_n     = 0;
    #1;
    check("rst_rgo",   host_rgo,     0);
    check("rst_wgo",   host_wgo,     0);
    check("rst_re",    host_re,      0);
    check("rst_we",    host_we,      0);
    check("rst_done",  req_done,     0);
    check("rst_rsp",   rsp_data,     0);
    check("rst_addr",  cpu_addr,     0);
    check("rst_wdata", host_wr_data, 0);
    check("rst_count", xfer_count,   0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    last_done = '0;
    while (last_done == '0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, last_done != '0, 1);
  endtask

  task automatic drain();
    req_valid     = '0;
    host_rd_ready = 1;
    host_wr_ready = 1;
    for (int n = 0; n < 10 && m_busy; n++) tick();
    host_rd_ready = 0;
    host_wr_ready = 0;
    tick();
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [N-1:0] pend_new;
  logic [N-1:0] pend_old;

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    rst_n         = 0;
    host_init     = 0;
    req_valid     = '0;
    req_we        = '0;
    req_addr      = '0;
    req_wdata     = '0;
    host_rd_ready = 0;
    host_wr_ready = 0;
    host_rd_data  = '0;
    auto_drop     = 1;
    last_done     = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Startup gating: no grant before host_init, rgo two cycles after it.
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 32'h0000_0040;
    repeat (4) tick();
    host_init = 1;
    tick();
    tick();
    #1 check("init_rgo", host_rgo, 1);
    host_rd_ready = 1;
    tick();
    host_rd_ready = 0;

    // Single read from requester 2; only the low 16 address bits reach the
    // host, so 0x1_2345 maps to 0x2345 << 2.
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 32'h0001_2345;
    host_rd_data = {64{8'hA5}};
    tick();
    repeat (5) tick();
    host_rd_ready = 1;
    #1;
    check("rd_addr", cpu_addr, 64'h0000_0000_0000_8D14);
    check("rd_re",   host_re,  1);
    check("rd_done", req_done, 4'b0100);
    check("rd_data", rsp_data, {64{8'hA5}});
    tick();
    host_rd_ready = 0;
    #1 check("rd_count", xfer_count, 32'd2);

    // Round-robin fairness from reset: each requester drops for one cycle
    // after its done, then re-raises.
    do_reset();
    host_init = 1;
    req_we    = '0;
    req_valid = 4'hF;
    pend_new  = '0;
    pend_old  = '0;
    done_log.delete();
    n = 0;
    while (done_log.size() < 8 && n < 400) begin
      req_valid     = req_valid | pend_old;
      pend_old      = pend_new;
      host_rd_ready = ($urandom_range(0, 2) == 0);
      host_rd_data  = rand_line();
      tick();
      pend_new = last_done;
      n++;
    end
    check("rr_count", done_log.size() >= 8, 1);
    for (int i = 0; i < 8 && i < done_log.size(); i++) check("rr_order", done_log[i], i % 4);
    drain();

    // Write-back from requester 1 with stray read-ready pulses.
    req_we    = 4'b0010;
    req_wdata[1*LW +: LW] = {16{32'hDEAD_BEEF}};
    req_valid = 4'b0010;
    tick();
    repeat (3) begin
      host_rd_ready = 1;
      tick();
      host_rd_ready = 0;
      tick();
    end
    host_wr_ready = 1;
    #1;
    check("wb_data", host_wr_data, {16{32'hDEAD_BEEF}});
    check("wb_wgo",  host_wgo,     1);
    check("wb_we",   host_we,      1);
    check("wb_done", req_done,     4'b0010);
    tick();
    host_wr_ready = 0;
    req_we        = '0;
    tick();

    // Reset in the middle of a read, then a one-cycle read after restart.
    req_valid = 4'b0001;
    req_addr[0 +: AW] = $urandom;
    tick();
    tick();
    #1 check("mid_rgo", host_rgo, 1);
    do_reset();
    repeat (3) tick();
    host_init     = 1;
    host_rd_ready = 1;
    wait_done("restart_done", 6);
    host_rd_ready = 0;

    // Saturation, plus a requester that drops valid mid-read.
    force dut.xfer_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.xfer_count_q;
    m_count = 32'hFFFF_FFFE;
    req_valid = 4'b1000;
    tick();
    tick();
    req_valid = '0;
    tick();
    host_rd_ready = 1;
    #1 check("drop_done", req_done, 4'b1000);
    tick();
    host_rd_ready = 0;
    #1 check("sat_max", xfer_count, 32'hFFFF_FFFF);
    req_valid     = 4'b0001;
    host_rd_ready = 1;
    wait_done("sat_done", 6);
    host_rd_ready = 0;
    #1 check("sat_hold", xfer_count, 32'hFFFF_FFFF);

    // Randomized traffic.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i]          = 1'b1;
          req_we[i]             = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*LW +: LW] = rand_line();
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*LW +: LW] = rand_line();
        end else if (req_valid[i] && m_busy && m_g == i && $urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      host_rd_ready = ($urandom_range(0, 2) == 0);
      host_wr_ready = ($urandom_range(0, 2) == 0);
      host_init     = 1'($urandom_range(0, 1));
      host_rd_data  = rand_line();
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1);
  end

endmodule
